smoothing_filter: RTL

- Moving-average filter for the accelerometer X/Y sample stream; produces smoothing_filter_out_x/y, which scale_and_saturate consumes to make pixel coordinates.
- Sits between the accelerometer sample source and scale_and_saturate.
- Averages the last 2^DEPTH_LOG2 samples per axis using a circular buffer and a running sum.
- Each accepted sample produces one updated average with a one-cycle valid strobe.

---
 rtl/smoothing_filter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/smoothing_filter.sv
// smoothing_filter: per-axis moving average over the last 2**DEPTH_LOG2
// accelerometer samples. A circular history buffer feeds a running sum
// (stage 1); the registered average and its one-cycle strobe follow on the
// next edge (stage 2). Empty history slots read as zero, so during warm-up
// the output is sum/N rather than sum/count.
module smoothing_filter #(
  parameter int DEPTH_LOG2 = 3,
  parameter int DATA_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample_x,
  input  logic signed [DATA_W-1:0] sample_y,
  output logic signed [DATA_W-1:0] smoothing_filter_out_x,
  output logic signed [DATA_W-1:0] smoothing_filter_out_y,
  output logic                     out_valid,
  output logic                     window_full
);

  localparam int N      = 1 << DEPTH_LOG2;
  localparam int SUM_W  = DATA_W + DEPTH_LOG2;
  localparam int FILL_W = DEPTH_LOG2 + 1;
  localparam logic [FILL_W-1:0] FILL_N = FILL_W'(N);

  // Floor division by N: arithmetic shift rounds toward -inf. The quotient
  // always fits in DATA_W because the sum is bounded by N*min..N*max.
  function automatic logic signed [DATA_W-1:0] avg_floor(input logic signed [SUM_W-1:0] s);
    return DATA_W'(s >>> DEPTH_LOG2);
  endfunction

  logic signed [DATA_W-1:0] hist_x_q [N];
  logic signed [DATA_W-1:0] hist_y_q [N];
  logic signed [SUM_W-1:0]  sum_x_q, sum_x_d;
  logic signed [SUM_W-1:0]  sum_y_q, sum_y_d;
  logic [DEPTH_LOG2-1:0]    wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]        fill_q, fill_d;
  logic                     vld_p1_q;
  logic                     clr_p1_q;

  logic signed [DATA_W-1:0] out_x_p2_q;
  logic signed [DATA_W-1:0] out_y_p2_q;
  logic                     vld_p2_q;
  logic                     full_q;

  // Next running sums: add the new sample, retire the entry it overwrites.
  always_comb begin
    sum_x_d  = sum_x_q + SUM_W'(sample_x) - SUM_W'(hist_x_q[wr_ptr_q]);
    sum_y_d  = sum_y_q + SUM_W'(sample_y) - SUM_W'(hist_y_q[wr_ptr_q]);
    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    fill_d   = (fill_q == FILL_N) ? fill_q : fill_q + FILL_W'(1);
  end

  // ---- stage 1: history write, running sums, pointer and fill count ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        hist_x_q[i] <= '0;
        hist_y_q[i] <= '0;
      end
      sum_x_q  <= '0;
      sum_y_q  <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      vld_p1_q <= 1'b0;
      clr_p1_q <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < N; i++) begin
        hist_x_q[i] <= '0;
        hist_y_q[i] <= '0;
      end
      sum_x_q  <= '0;
      sum_y_q  <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      vld_p1_q <= 1'b0;
      clr_p1_q <= 1'b1;
    end else begin
      vld_p1_q <= sample_valid;
      clr_p1_q <= 1'b0;
      if (sample_valid) begin
        hist_x_q[wr_ptr_q] <= sample_x;
        hist_y_q[wr_ptr_q] <= sample_y;
        sum_x_q            <= sum_x_d;
        sum_y_q            <= sum_y_d;
        wr_ptr_q           <= wr_ptr_d;
        fill_q             <= fill_d;
      end
    end
  end

  // ---- stage 2: registered averages, strobe and window-full flag ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_x_p2_q <= '0;
      out_y_p2_q <= '0;
      vld_p2_q   <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      vld_p2_q <= vld_p1_q;
      if (clr_p1_q) begin
        out_x_p2_q <= '0;
        out_y_p2_q <= '0;
      end else if (vld_p1_q) begin
        out_x_p2_q <= avg_floor(sum_x_q);
        out_y_p2_q <= avg_floor(sum_y_q);
      end
      // A clear on this edge beats the flag rising for an in-flight sample.
      if (clear) begin
        full_q <= 1'b0;
      end else if (vld_p1_q && (fill_q == FILL_N)) begin
        full_q <= 1'b1;
      end
    end
  end

  assign smoothing_filter_out_x = out_x_p2_q;
  assign smoothing_filter_out_y = out_y_p2_q;
  assign out_valid              = vld_p2_q;
  assign window_full            = full_q;

endmodule
